// File: rtl/sd_filler_pkg.sv
// sd_filler_pkg: shared Wishbone burst codes, filler FSM states and Gray-code helpers.
package sd_filler_pkg;
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  typedef enum logic [2:0] {IDLE, WAIT_SPACE, BURST, DONE, ERROR} state_t;
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    for (int i = 1; i < 32; i++) b = b ^ (g >> i);
    return b;
  endfunction
endpackage

// File: rtl/sd_tx_fifo_async.sv
// sd_tx_fifo_async: dual-clock Gray-pointer FIFO, write side on clk, read side on sd_clk,
// with a conservative fill level exported to the write domain.
module sd_tx_fifo_async
  import sd_filler_pkg::*;
#(
  parameter int DW         = 32,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_wr,
  input  logic [DW-1:0]         i_din,
  output logic                  o_full,
  output logic [DEPTH_LOG2:0]   o_wr_level,
  input  logic                  sd_clk,
  input  logic                  i_rd,
  output logic [DW-1:0]         o_dout,
  output logic                  o_empty
);
  localparam int PW = DEPTH_LOG2 + 1;
  logic [DW-1:0] r_mem [2**DEPTH_LOG2];
  logic [PW-1:0] r_wbin, r_wgray, r_rq1, r_rq2;
  logic [PW-1:0] r_rbin, r_rgray, r_wq1, r_wq2;
  logic [DW-1:0] r_dout;
  logic [PW-1:0] w_wnext, w_rnext;
  logic          w_rd;
  assign w_wnext    = r_wbin + PW'(1);
  assign w_rnext    = r_rbin + PW'(1);
  assign o_wr_level = r_wbin - PW'(gray2bin(32'(r_rq2)));
  assign o_full     = o_wr_level == PW'(2**DEPTH_LOG2);
  assign o_empty    = r_rgray == r_wq2;
  assign w_rd       = i_rd & ~o_empty;
  assign o_dout     = r_dout;
  always_ff @(posedge clk) if (i_wr) r_mem[r_wbin[DEPTH_LOG2-1:0]] <= i_din;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wbin  <= '0;
      r_wgray <= '0;
      r_rq1   <= '0;
      r_rq2   <= '0;
    end else begin
      r_rq1 <= r_rgray;
      r_rq2 <= r_rq1;
      if (i_wr) begin
        r_wbin  <= w_wnext;
        r_wgray <= PW'(bin2gray(32'(w_wnext)));
      end
    end
  end
  always_ff @(posedge sd_clk or posedge rst) begin
    if (rst) begin
      r_rbin  <= '0;
      r_rgray <= '0;
      r_wq1   <= '0;
      r_wq2   <= '0;
      r_dout  <= '0;
    end else begin
      r_wq1 <= r_wgray;
      r_wq2 <= r_wq1;
      if (w_rd) begin
        r_dout  <= r_mem[r_rbin[DEPTH_LOG2-1:0]];
        r_rbin  <= w_rnext;
        r_rgray <= PW'(bin2gray(32'(w_rnext)));
      end
    end
  end
endmodule

// File: rtl/sd_fifo_tx_burst_filler.sv
// sd_fifo_tx_burst_filler: Wishbone incrementing-burst master prefetching xfer_len words
// from memory into the dual-clock SD TX FIFO, with done/err reporting.
module sd_fifo_tx_burst_filler
  import sd_filler_pkg::*;
#(
  parameter int DW         = 32,
  parameter int AW         = 32,
  parameter int DEPTH_LOG2 = 4,
  parameter int BURST_LEN  = 4,
  parameter int LEN_W      = 12
) (
  input  logic              clk,
  input  logic              rst,
  output logic [AW-1:0]     m_wb_adr_o,
  output logic [DW/8-1:0]   m_wb_sel_o,
  output logic              m_wb_we_o,
  input  logic [DW-1:0]     m_wb_dat_i,
  output logic              m_wb_cyc_o,
  output logic              m_wb_stb_o,
  input  logic              m_wb_ack_i,
  input  logic              m_wb_err_i,
  output logic [2:0]        m_wb_cti_o,
  output logic [1:0]        m_wb_bte_o,
  input  logic              en,
  input  logic [AW-1:0]     adr,
  input  logic [LEN_W-1:0]  xfer_len,
  output logic              done,
  output logic              err,
  input  logic              sd_clk,
  input  logic              rd,
  output logic [DW-1:0]     dat_o,
  output logic              empty,
  output logic              fe
);
  localparam int PW = DEPTH_LOG2 + 1;
  state_t           r_state, w_state;
  logic             r_en_d;
  logic [AW-1:0]    r_adr;
  logic [LEN_W-1:0] r_rem, r_beats, w_need;
  logic [PW-1:0]    w_level, w_free;
  logic             w_rise, w_launch, w_wr, w_clr, w_cyc;
  assign w_rise = en & ~r_en_d;
  assign w_need = (r_rem > LEN_W'(BURST_LEN)) ? LEN_W'(BURST_LEN) : r_rem;
  assign w_free = PW'(2**DEPTH_LOG2) - w_level;
  // Dropping en flushes both FIFO domains for as long as it stays low.
  assign w_clr  = rst | ~en;
  assign w_cyc  = r_state == BURST;
  assign m_wb_cyc_o = w_cyc;
  assign m_wb_stb_o = w_cyc;
  assign m_wb_we_o  = 1'b0;
  assign m_wb_sel_o = '1;
  assign m_wb_bte_o = BTE_LINEAR;
  assign m_wb_cti_o = !w_cyc ? CTI_CLASSIC : (r_beats == LEN_W'(1)) ? CTI_EOB : CTI_INCR;
  assign m_wb_adr_o = r_adr;
  assign done = r_state == DONE;
  assign err  = r_state == ERROR;
  always_comb begin
    w_state  = r_state;
    w_launch = 1'b0;
    w_wr     = 1'b0;
    if (!en) w_state = IDLE;
    else case (r_state)
      IDLE:       if (w_rise) w_state = (xfer_len == '0) ? DONE : WAIT_SPACE;
      WAIT_SPACE: if (32'(w_free) >= 32'(w_need)) begin
        w_launch = 1'b1;
        w_state  = BURST;
      end
      BURST:      if (m_wb_err_i) w_state = ERROR;
        else if (m_wb_ack_i) begin
        w_wr = 1'b1;
        if (r_beats == LEN_W'(1)) w_state = (r_rem == LEN_W'(1)) ? DONE : WAIT_SPACE;
      end
      DONE, ERROR: w_state = r_state;
      default:    w_state = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_en_d  <= 1'b0;
      r_adr   <= '0;
      r_rem   <= '0;
      r_beats <= '0;
    end else begin
      r_state <= w_state;
      r_en_d  <= en;
      if (w_rise) begin
        r_adr <= adr;
        r_rem <= xfer_len;
      end
      if (w_launch) r_beats <= w_need;
      if (w_wr) begin
        r_adr   <= r_adr + AW'(DW/8);
        r_rem   <= r_rem - LEN_W'(1);
        r_beats <= r_beats - LEN_W'(1);
      end
    end
  end
  sd_tx_fifo_async #(.DW(DW), .DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .clk        (clk),
    .rst        (w_clr),
    .i_wr       (w_wr),
    .i_din      (m_wb_dat_i),
    .o_full     (fe),
    .o_wr_level (w_level),
    .sd_clk     (sd_clk),
    .i_rd       (rd),
    .o_dout     (dat_o),
    .o_empty    (empty)
  );
  // The space check must make an ack into a full FIFO impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(w_wr && fe));
endmodule

// File: tb/tb_sd_fifo_tx_burst_filler.sv
// tb_sd_fifo_tx_burst_filler: directed vector table plus hand-written stall/abort sequences
// against a zero-wait Wishbone slave model with programmable error injection.
module tb_sd_fifo_tx_burst_filler;
  logic        clk = 1'b0, sd_clk = 1'b0, rst = 1'b1;
  logic [31:0] m_wb_adr_o, m_wb_dat_i, adr = '0, dat_o;
  logic [3:0]  m_wb_sel_o;
  logic        m_wb_we_o, m_wb_cyc_o, m_wb_stb_o, m_wb_ack_i, m_wb_err_i;
  logic [2:0]  m_wb_cti_o;
  logic [1:0]  m_wb_bte_o;
  logic        en = 1'b0, rd = 1'b0, done, err, empty, fe;
  logic [11:0] xfer_len = '0;
  int          n_cmp = 0, n_bad = 0;
  int          beat_idx = 0, err_beat = 0;
  logic        ack_err = 1'b0, cyc_seen = 1'b0, err_now;
  logic [31:0] rec_adr [64];
  logic [2:0]  rec_cti [64];
  typedef struct {
    logic [31:0] a;
    int          len;
    int          eb;
    logic        ae;
    logic        xd;
    logic        xe;
    int          xw;
  } vec_t;
  vec_t v [8];

  always #5 clk = ~clk;
  always #7 sd_clk = ~sd_clk;

  function automatic logic [31:0] dat_of(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  assign err_now    = m_wb_cyc_o && (err_beat != 0) && (beat_idx == err_beat - 1);
  assign m_wb_err_i = err_now;
  assign m_wb_ack_i = m_wb_cyc_o && m_wb_stb_o && (!err_now || ack_err);
  assign m_wb_dat_i = dat_of(m_wb_adr_o);

  always @(posedge clk) begin
    beat_idx <= !en ? 0 : beat_idx + ((m_wb_ack_i && !m_wb_err_i) ? 1 : 0);
    cyc_seen <= !en ? 1'b0 : (cyc_seen | m_wb_cyc_o);
  end
  always @(negedge clk)
    if (m_wb_ack_i && !m_wb_err_i && beat_idx < 64) begin
      rec_adr[beat_idx] = m_wb_adr_o;
      rec_cti[beat_idx] = m_wb_cti_o;
    end

  sd_fifo_tx_burst_filler dut (
    .clk(clk), .rst(rst),
    .m_wb_adr_o(m_wb_adr_o), .m_wb_sel_o(m_wb_sel_o), .m_wb_we_o(m_wb_we_o),
    .m_wb_dat_i(m_wb_dat_i), .m_wb_cyc_o(m_wb_cyc_o), .m_wb_stb_o(m_wb_stb_o),
    .m_wb_ack_i(m_wb_ack_i), .m_wb_err_i(m_wb_err_i), .m_wb_cti_o(m_wb_cti_o),
    .m_wb_bte_o(m_wb_bte_o), .en(en), .adr(adr), .xfer_len(xfer_len),
    .done(done), .err(err), .sd_clk(sd_clk), .rd(rd), .dat_o(dat_o),
    .empty(empty), .fe(fe)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic start(input logic [31:0] a, input int l);
    @(negedge clk) en = 1'b0;
    repeat (3) @(negedge clk);
    adr = a;
    xfer_len = 12'(l);
    en = 1'b1;
  endtask

  task automatic wait_end();
    for (int k = 0; k < 400 && !(done || err); k++) @(negedge clk);
    repeat (2) @(negedge clk);
  endtask

  task automatic pop(input logic [31:0] exp, input string nm);
    for (int k = 0; k < 20 && empty; k++) @(negedge sd_clk);
    @(negedge sd_clk) rd = 1'b1;
    @(negedge sd_clk) rd = 1'b0;
    chk(nm, dat_o, exp);
  endtask

  task automatic check_beats(input logic [31:0] a, input int len, input int first, input int last);
    logic [31:0] ea;
    int bs, bsz;
    for (int i = first; i < last; i++) begin
      ea  = a + 32'(4 * i);
      bs  = (i / 4) * 4;
      bsz = (len - bs < 4) ? len - bs : 4;
      chk($sformatf("beat%0d_adr", i), rec_adr[i], ea);
      chk($sformatf("beat%0d_cti", i), 32'(rec_cti[i]), (i - bs == bsz - 1) ? 32'd7 : 32'd2);
    end
  endtask

  task automatic drain(input logic [31:0] a, input int first, input int last);
    for (int i = first; i < last; i++) pop(dat_of(a + 32'(4 * i)), $sformatf("word%0d", i));
    repeat (3) @(negedge sd_clk);
    chk("empty_after_drain", empty, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    v[0] = '{32'h0000_1000,  8, 0, 1'b0, 1'b1, 1'b0,  8};
    v[1] = '{32'h0000_2000,  6, 0, 1'b0, 1'b1, 1'b0,  6};
    v[2] = '{32'h0000_3000,  8, 3, 1'b0, 1'b0, 1'b1,  2};
    v[3] = '{32'h0000_3400,  4, 1, 1'b1, 1'b0, 1'b1,  0};
    v[4] = '{32'h0000_0000,  0, 0, 1'b0, 1'b1, 1'b0,  0};
    v[5] = '{32'hFFFF_FFF8,  4, 0, 1'b0, 1'b1, 1'b0,  4};
    v[6] = '{32'h0000_4000,  1, 0, 1'b0, 1'b1, 1'b0,  1};
    v[7] = '{32'h0000_6000, 16, 0, 1'b0, 1'b1, 1'b0, 16};
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_cyc", m_wb_cyc_o, 0);
    chk("rst_stb", m_wb_stb_o, 0);
    chk("rst_we", m_wb_we_o, 0);
    chk("rst_cti", 32'(m_wb_cti_o), 0);
    chk("rst_bte", 32'(m_wb_bte_o), 0);
    chk("rst_sel", 32'(m_wb_sel_o), 32'hF);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_empty", empty, 1);
    chk("rst_fe", fe, 0);

    for (int n = 0; n < 8; n++) begin
      err_beat = v[n].eb;
      ack_err  = v[n].ae;
      start(v[n].a, v[n].len);
      if (v[n].len == 0) begin
        @(negedge clk);
        chk("len0_done_1clk", done, 1);
      end
      wait_end();
      chk($sformatf("v%0d_done", n), done, v[n].xd);
      chk($sformatf("v%0d_err", n), err, v[n].xe);
      chk($sformatf("v%0d_cyc_idle", n), m_wb_cyc_o, 0);
      chk($sformatf("v%0d_beats", n), beat_idx, v[n].xw);
      chk($sformatf("v%0d_cyc_seen", n), cyc_seen, v[n].len != 0);
      chk($sformatf("v%0d_fe", n), fe, v[n].xw == 16);
      check_beats(v[n].a, v[n].len, 0, v[n].xw);
      drain(v[n].a, 0, v[n].xw);
      @(negedge clk) en = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d_done_clr", n), done, 0);
      chk($sformatf("v%0d_err_clr", n), err, 0);
    end
    err_beat = 0;
    ack_err  = 1'b0;

    start(32'h0000_8000, 20);
    repeat (60) @(negedge clk);
    chk("stall_beats", beat_idx, 16);
    chk("stall_fe", fe, 1);
    chk("stall_cyc", m_wb_cyc_o, 0);
    chk("stall_done", done, 0);
    drain_partial: for (int i = 0; i < 4; i++) pop(dat_of(32'h8000 + 32'(4 * i)), $sformatf("stall_word%0d", i));
    wait_end();
    chk("stall_done_end", done, 1);
    chk("stall_beats_end", beat_idx, 20);
    check_beats(32'h0000_8000, 20, 0, 20);
    drain(32'h0000_8000, 4, 20);

    start(32'h0000_5000, 8);
    for (int k = 0; k < 50 && beat_idx != 2; k++) @(negedge clk);
    chk("abort_cyc_before", m_wb_cyc_o, 1);
    en = 1'b0;
    @(negedge clk);
    chk("abort_cyc", m_wb_cyc_o, 0);
    chk("abort_stb", m_wb_stb_o, 0);
    repeat (3) @(negedge sd_clk);
    chk("abort_empty", empty, 1);
    chk("abort_done", done, 0);
    start(32'h0000_5000, 2);
    wait_end();
    chk("restart_done", done, 1);
    chk("restart_beats", beat_idx, 2);
    check_beats(32'h0000_5000, 2, 0, 2);
    drain(32'h0000_5000, 0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
